mem_stage_hs: RTL and testbench
===============================

MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 Parameter: XLEN, 32, datapath width; legal values 32 or 64.
REQ-002 Parameter: BYTE_OFS, $clog2(XLEN/8), address bits selecting a byte in a data word.
REQ-003 Port: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: resetn  input  1  synchronous, active-low reset.
REQ-005 Port: es_to_ms_valid  input  1  EX holds a valid instruction.
REQ-006 Port: ms_allowin  output  1  MEM accepts a new instruction this cycle.
REQ-007 Port: es_pc, es_alu_result  input  XLEN  instruction PC; ALU result or effective address.
REQ-008 Port: es_res_from_mem, es_mem_req  input  1  load writeback from memory; EX issued an accepted bus request.
REQ-009 Port: es_ld_op  input  3  load op: 0 W, 1 B, 2 BU, 3 H, 4 HU, 5 WU, 6 D (5 and 6 legal only when XLEN=64).
REQ-010 Port: es_rf_we, es_rf_waddr  input  1/5  regfile write enable and address.
REQ-011 Port: flush  input  1  discard the MEM instruction this cycle.
REQ-012 Port: data_ok, data_rdata  input  1/XLEN  bus response strobe and read data.
REQ-013 Port: ws_allowin  input  1; ms_to_ws_valid  output  1  WB handshake.
REQ-014 Port: ms_pc  output  XLEN; ms_rf_we  output  1; ms_rf_waddr  output  5; ms_rf_wdata  output  XLEN.
REQ-015 Port: ms_fwd_valid  output  1  ms_rf_wdata is final and forwardable; ms_ale  output  1  misaligned-load exception.

Function
REQ-016 Stage transfer SHALL occur when es_to_ms_valid && ms_allowin; ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
REQ-017 Response FSM states SHALL be IDLE, WAIT, HOLD and CANCEL.
REQ-018 Transfer with es_mem_req=1 SHALL enter WAIT; transfer with es_mem_req=0 SHALL enter or stay IDLE.
REQ-019 WAIT with data_ok=1 SHALL capture data_rdata into a hold register: if ws_allowin is 1 in that cycle, return to IDLE (or WAIT if a new request transfers in); otherwise go to HOLD.
REQ-020 HOLD SHALL leave when the instruction moves to WB.
REQ-021 ms_ready_go SHALL be 1 in IDLE and HOLD, and in WAIT only in the cycle data_ok=1; in CANCEL it SHALL be 0.
REQ-022 flush in WAIT without data_ok SHALL clear ms_valid and enter CANCEL.
REQ-023 CANCEL SHALL drop the next data_ok without writeback, then return to IDLE.
REQ-024 ms_allowin SHALL be 0 in CANCEL.
REQ-025 flush in any other state SHALL clear ms_valid and return to IDLE.
REQ-026 flush coincident with data_ok SHALL consume the response and go to IDLE.
REQ-027 Load data SHALL be data_rdata (or the hold register) shifted right by {addr[BYTE_OFS-1:0],3'b000}.
REQ-028 The shifted data SHALL be extended: B/H/W sign-extend bit 7/15/31; BU/HU/WU zero-extend; D passes through; W at XLEN=32 passes through.
REQ-029 ms_rf_wdata SHALL equal the extended load data when res_from_mem, else the latched alu_result.
REQ-030 ms_ale SHALL be ms_valid && res_from_mem && misaligned: H/HU with addr[0]!=0; W/WU with addr[1:0]!=0; D with addr[2:0]!=0.
REQ-031 When ms_ale=1, ms_ready_go SHALL be 1 without waiting for data_ok, and ms_rf_we SHALL be 0.
REQ-032 ms_rf_we SHALL be latched_we && ms_valid && !ms_ale.
REQ-033 ms_fwd_valid SHALL be ms_valid && ms_rf_we && ms_ready_go.
REQ-034 An illegal es_ld_op (7, or 5/6 at XLEN=32) SHALL be treated as W.

Reset
REQ-035 With resetn=0 at a clock edge: ms_valid=0, FSM=IDLE, ms_pc=0, ms_rf_waddr=0, latched we/res_from_mem/alu_result/hold=0.
REQ-036 During and after reset: ms_to_ws_valid=0, ms_rf_we=0, ms_fwd_valid=0, ms_ale=0, ms_allowin=1.
REQ-037 Reset in WAIT or CANCEL SHALL abandon the outstanding response with no CANCEL tracking.

Structure
REQ-038 A shared package SHALL hold the ld_op encodings and the FSM state enum.
REQ-039 One sub-module, load_align (combinational shift and extend, parametrised by XLEN), SHALL be instantiated once.

Verification
REQ-040 XLEN=32, LD.B, addr 0x1003, data_ok next cycle, rdata 0x80FF_0000 -> ms_rf_wdata 0xFFFF_FF80, ms_to_ws_valid for 1 cycle.
REQ-041 LD.HU, addr 0x2002, data_ok after 3 cycles with ws_allowin=0 -> FSM in HOLD, ms_allowin=0; when ws_allowin=1 -> wdata 0x0000_80FF from rdata 0x80FF_1234.
REQ-042 LD.W, addr 0x3001 -> ms_ale=1 and ms_rf_we=0 in the first valid cycle; no data_ok required.
REQ-043 flush in WAIT, stray data_ok 2 cycles later with rdata 0xDEAD_BEEF -> no writeback, ms_allowin=0 until the drop, then 1.
REQ-044 XLEN=64, LD.WU, addr 0x…04, rdata 0x8765_4321_0000_0000 -> wdata 0x0000_0000_8765_4321.
REQ-045 Back-to-back ALU ops with ws_allowin=1 -> one result per cycle, ms_fwd_valid=1 each cycle.

Source files
------------

// File: rtl/mem_stage_hs_pkg.sv
// mem_stage_hs_pkg -- shared definitions for the MEM pipeline stage.
//   ld_op_e     : load operation encodings as delivered by EX
//   ms_state_e  : bus-response tracking states of the MEM stage
//   norm_ld_op  : folds illegal load encodings onto LD_W
package mem_stage_hs_pkg;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4,
    LD_WU = 3'd5,
    LD_D  = 3'd6
  } ld_op_e;

  typedef enum logic [1:0] {
    MS_IDLE   = 2'd0,
    MS_WAIT   = 2'd1,
    MS_HOLD   = 2'd2,
    MS_CANCEL = 2'd3
  } ms_state_e;

  // WU and D only exist on a 64-bit datapath; everything unknown behaves as W.
  function automatic ld_op_e norm_ld_op(input logic [2:0] op, input logic is_64);
    ld_op_e r;
    case (op)
      3'd1:    r = LD_B;
      3'd2:    r = LD_BU;
      3'd3:    r = LD_H;
      3'd4:    r = LD_HU;
      3'd5:    r = is_64 ? LD_WU : LD_W;
      3'd6:    r = is_64 ? LD_D : LD_W;
      default: r = LD_W;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_hs_load_align.sv
// load_align -- combinational load data alignment.
//   rdata    : raw bus read data word
//   byte_ofs : byte offset of the load address within the word
//   ld_op    : normalised load operation (ld_op_e encoding)
//   data     : read data shifted down to bit 0 and sign/zero extended
module load_align
  import mem_stage_hs_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int BYTE_OFS = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]     rdata,
  input  logic [BYTE_OFS-1:0] byte_ofs,
  input  logic [2:0]          ld_op,
  output logic [XLEN-1:0]     data
);

  logic [BYTE_OFS+2:0] shamt;
  logic [XLEN-1:0]     shifted;

  assign shamt   = {byte_ofs, 3'b000};
  assign shifted = rdata >> shamt;

  // A size cast of a signed operand sign-extends, which avoids zero-width
  // replications when XLEN is 32 and the operand is a full word.
  always_comb begin
    data = shifted;
    case (ld_op_e'(ld_op))
      LD_B:    data = XLEN'($signed(shifted[7:0]));
      LD_BU:   data = XLEN'(shifted[7:0]);
      LD_H:    data = XLEN'($signed(shifted[15:0]));
      LD_HU:   data = XLEN'(shifted[15:0]);
      LD_W:    data = XLEN'($signed(shifted[31:0]));
      LD_WU:   data = XLEN'(shifted[31:0]);
      LD_D:    data = shifted;
      default: data = XLEN'($signed(shifted[31:0]));
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// mem_stage_hs -- MEM pipeline stage with valid/allowin handshakes and
// bus-response tracking (wait, hold, cancel of an orphaned response).
//   clk, resetn         : clock, synchronous active-low reset
//   es_*                : instruction offered by EX (valid, pc, alu result /
//                         address, load info, regfile write info, bus request)
//   ms_allowin          : MEM accepts an instruction this cycle
//   flush               : discard the instruction held in MEM
//   data_ok, data_rdata : bus response strobe and read data
//   ws_allowin          : WB accepts; ms_to_ws_valid offers to WB
//   ms_pc, ms_rf_*      : instruction PC and regfile write info for WB
//   ms_fwd_valid        : ms_rf_wdata is final and may be forwarded
//   ms_ale              : misaligned load exception
module mem_stage_hs
  import mem_stage_hs_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int BYTE_OFS = $clog2(XLEN / 8)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            es_to_ms_valid,
  output logic            ms_allowin,
  input  logic [XLEN-1:0] es_pc,
  input  logic [XLEN-1:0] es_alu_result,
  input  logic            es_res_from_mem,
  input  logic            es_mem_req,
  input  logic [2:0]      es_ld_op,
  input  logic            es_rf_we,
  input  logic [4:0]      es_rf_waddr,
  input  logic            flush,
  input  logic            data_ok,
  input  logic [XLEN-1:0] data_rdata,
  input  logic            ws_allowin,
  output logic            ms_to_ws_valid,
  output logic [XLEN-1:0] ms_pc,
  output logic            ms_rf_we,
  output logic [4:0]      ms_rf_waddr,
  output logic [XLEN-1:0] ms_rf_wdata,
  output logic            ms_fwd_valid,
  output logic            ms_ale
);

  localparam logic IS_64 = (XLEN == 64);

  ms_state_e       state_reg, state_next;
  logic            ms_valid_reg, ms_valid_next;
  logic [XLEN-1:0] pc_reg, alu_result_reg, hold_reg;
  logic            res_from_mem_reg, rf_we_reg;
  logic [4:0]      rf_waddr_reg;
  ld_op_e          ld_op_reg;

  logic            ms_ready_go, ms_go, es_fire, hold_load;
  logic            misaligned, owe_response;
  logic [XLEN-1:0] load_src, load_data;

  // ---------------- handshake ----------------
  always_comb begin
    ms_ready_go = 1'b0;
    case (state_reg)
      MS_IDLE:   ms_ready_go = 1'b1;
      MS_HOLD:   ms_ready_go = 1'b1;
      MS_WAIT:   ms_ready_go = data_ok || ms_ale;
      MS_CANCEL: ms_ready_go = 1'b0;
      default:   ms_ready_go = 1'b0;
    endcase
  end

  // A misaligned load may leave WAIT before its response arrives; the stage
  // then heads to CANCEL, so it must not accept a new instruction that cycle.
  assign owe_response = (state_reg == MS_WAIT) && !data_ok;

  assign ms_allowin = (state_reg != MS_CANCEL) && !(ms_ale && owe_response) &&
                      (!ms_valid_reg || (ms_ready_go && ws_allowin));

  assign es_fire        = es_to_ms_valid && ms_allowin && !flush;
  assign ms_go          = ms_valid_reg && ms_ready_go && ws_allowin;
  assign ms_to_ws_valid = ms_valid_reg && ms_ready_go && !flush;

  // ---------------- response FSM ----------------
  always_comb begin
    state_next    = state_reg;
    ms_valid_next = ms_valid_reg;
    hold_load     = 1'b0;

    if (ms_go)   ms_valid_next = 1'b0;
    if (es_fire) ms_valid_next = 1'b1;
    if (flush)   ms_valid_next = 1'b0;

    case (state_reg)
      MS_IDLE: begin
        if (es_fire) state_next = es_mem_req ? MS_WAIT : MS_IDLE;
      end
      MS_WAIT: begin
        if (data_ok) begin
          if (flush) begin
            state_next = MS_IDLE;          // response consumed with the flush
          end else begin
            hold_load = 1'b1;
            if (ws_allowin) state_next = (es_fire && es_mem_req) ? MS_WAIT : MS_IDLE;
            else            state_next = MS_HOLD;
          end
        end else if (flush || ms_go) begin
          state_next = MS_CANCEL;          // response still owed, nobody wants it
        end
      end
      MS_HOLD: begin
        if (flush)      state_next = MS_IDLE;
        else if (ms_go) state_next = (es_fire && es_mem_req) ? MS_WAIT : MS_IDLE;
      end
      MS_CANCEL: begin
        // Stay here even on flush: the orphaned response must still be eaten.
        if (data_ok) state_next = MS_IDLE;
      end
      default: state_next = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= MS_IDLE;
      ms_valid_reg <= 1'b0;
      hold_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      ms_valid_reg <= ms_valid_next;
      if (hold_load) hold_reg <= data_rdata;
    end
  end

  // ---------------- instruction latch ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_reg           <= '0;
      alu_result_reg   <= '0;
      res_from_mem_reg <= 1'b0;
      rf_we_reg        <= 1'b0;
      rf_waddr_reg     <= '0;
      ld_op_reg        <= LD_W;
    end else if (es_fire) begin
      pc_reg           <= es_pc;
      alu_result_reg   <= es_alu_result;
      res_from_mem_reg <= es_res_from_mem;
      rf_we_reg        <= es_rf_we;
      rf_waddr_reg     <= es_rf_waddr;
      ld_op_reg        <= norm_ld_op(es_ld_op, IS_64);
    end
  end

  // ---------------- load data and exceptions ----------------
  always_comb begin
    misaligned = 1'b0;
    case (ld_op_reg)
      LD_H, LD_HU: misaligned = alu_result_reg[0];
      LD_W, LD_WU: misaligned = |alu_result_reg[1:0];
      LD_D:        misaligned = |alu_result_reg[2:0];
      default:     misaligned = 1'b0;
    endcase
  end

  assign load_src = (state_reg == MS_HOLD) ? hold_reg : data_rdata;

  load_align #(
    .XLEN     (XLEN),
    .BYTE_OFS (BYTE_OFS)
  ) u_load_align (
    .rdata    (load_src),
    .byte_ofs (alu_result_reg[BYTE_OFS-1:0]),
    .ld_op    (ld_op_reg),
    .data     (load_data)
  );

  assign ms_ale       = ms_valid_reg && res_from_mem_reg && misaligned;
  assign ms_pc        = pc_reg;
  assign ms_rf_waddr  = rf_waddr_reg;
  assign ms_rf_we     = rf_we_reg && ms_valid_reg && !ms_ale;
  assign ms_rf_wdata  = res_from_mem_reg ? load_data : alu_result_reg;
  assign ms_fwd_valid = ms_valid_reg && ms_rf_we && ms_ready_go;

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs -- directed checks of mem_stage_hs at XLEN=32 (dut) and
// XLEN=64 (dut64); both instances share clock and reset.
module tb_mem_stage_hs;
  import mem_stage_hs_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // XLEN=32 instance signals
  logic        es_to_ms_valid, es_res_from_mem, es_mem_req, es_rf_we;
  logic        flush, data_ok, ws_allowin;
  logic [31:0] es_pc, es_alu_result, data_rdata;
  logic [2:0]  es_ld_op;
  logic [4:0]  es_rf_waddr;
  logic        ms_allowin, ms_to_ws_valid, ms_rf_we, ms_fwd_valid, ms_ale;
  logic [31:0] ms_pc, ms_rf_wdata;
  logic [4:0]  ms_rf_waddr;

  // XLEN=64 instance signals
  logic        x_es_to_ms_valid, x_es_res_from_mem, x_es_mem_req, x_es_rf_we;
  logic        x_flush, x_data_ok, x_ws_allowin;
  logic [63:0] x_es_pc, x_es_alu_result, x_data_rdata;
  logic [2:0]  x_es_ld_op;
  logic [4:0]  x_es_rf_waddr;
  logic        x_ms_allowin, x_ms_to_ws_valid, x_ms_rf_we, x_ms_fwd_valid, x_ms_ale;
  logic [63:0] x_ms_pc, x_ms_rf_wdata;
  logic [4:0]  x_ms_rf_waddr;

  mem_stage_hs #(.XLEN(32)) dut (
    .clk(clk), .resetn(resetn),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_alu_result(es_alu_result),
    .es_res_from_mem(es_res_from_mem), .es_mem_req(es_mem_req),
    .es_ld_op(es_ld_op), .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr),
    .flush(flush), .data_ok(data_ok), .data_rdata(data_rdata),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_pc(ms_pc), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
    .ms_rf_wdata(ms_rf_wdata), .ms_fwd_valid(ms_fwd_valid), .ms_ale(ms_ale)
  );

  mem_stage_hs #(.XLEN(64)) dut64 (
    .clk(clk), .resetn(resetn),
    .es_to_ms_valid(x_es_to_ms_valid), .ms_allowin(x_ms_allowin),
    .es_pc(x_es_pc), .es_alu_result(x_es_alu_result),
    .es_res_from_mem(x_es_res_from_mem), .es_mem_req(x_es_mem_req),
    .es_ld_op(x_es_ld_op), .es_rf_we(x_es_rf_we), .es_rf_waddr(x_es_rf_waddr),
    .flush(x_flush), .data_ok(x_data_ok), .data_rdata(x_data_rdata),
    .ws_allowin(x_ws_allowin), .ms_to_ws_valid(x_ms_to_ws_valid),
    .ms_pc(x_ms_pc), .ms_rf_we(x_ms_rf_we), .ms_rf_waddr(x_ms_rf_waddr),
    .ms_rf_wdata(x_ms_rf_wdata), .ms_fwd_valid(x_ms_fwd_valid), .ms_ale(x_ms_ale)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue32(input logic [2:0] op, input logic [31:0] addr, input logic mem_req,
                         input logic from_mem, input logic [4:0] waddr, input logic [31:0] pc);
    es_to_ms_valid  = 1'b1;
    es_ld_op        = op;
    es_alu_result   = addr;
    es_mem_req      = mem_req;
    es_res_from_mem = from_mem;
    es_rf_we        = 1'b1;
    es_rf_waddr     = waddr;
    es_pc           = pc;
  endtask

  // One 64-bit load: transfer, response in the next cycle, check the result.
  task automatic load64(input string tag, input logic [2:0] op, input logic [63:0] addr,
                        input logic [63:0] rdata, input logic [63:0] exp);
    x_es_to_ms_valid  = 1'b1;
    x_es_ld_op        = op;
    x_es_alu_result   = addr;
    x_es_mem_req      = 1'b1;
    x_es_res_from_mem = 1'b1;
    x_es_rf_we        = 1'b1;
    x_es_rf_waddr     = 5'd3;
    x_es_pc           = 64'h8000;
    step();
    x_es_to_ms_valid = 1'b0;
    x_data_ok        = 1'b1;
    x_data_rdata     = rdata;
    #1;
    check({tag, "_valid"}, x_ms_to_ws_valid, 1'b1);
    check({tag, "_wdata"}, x_ms_rf_wdata, exp);
    $display("txn xlen64 %s addr=0x%0h rdata=0x%0h wdata=0x%0h", tag, addr, rdata, x_ms_rf_wdata);
    step();
    x_data_ok = 1'b0;
  endtask

  initial begin
    es_to_ms_valid = 0; es_res_from_mem = 0; es_mem_req = 0; es_rf_we = 0;
    flush = 0; data_ok = 0; ws_allowin = 1;
    es_pc = 0; es_alu_result = 0; data_rdata = 0; es_ld_op = 0; es_rf_waddr = 0;
    x_es_to_ms_valid = 0; x_es_res_from_mem = 0; x_es_mem_req = 0; x_es_rf_we = 0;
    x_flush = 0; x_data_ok = 0; x_ws_allowin = 1;
    x_es_pc = 0; x_es_alu_result = 0; x_data_rdata = 0; x_es_ld_op = 0; x_es_rf_waddr = 0;

    // ---- reset ----
    resetn = 1'b0;
    step();
    step();
    check("rst_to_ws", ms_to_ws_valid, 1'b0);
    check("rst_rf_we", ms_rf_we, 1'b0);
    check("rst_fwd", ms_fwd_valid, 1'b0);
    check("rst_ale", ms_ale, 1'b0);
    check("rst_allowin", ms_allowin, 1'b1);
    check("rst_pc", ms_pc, 64'h0);
    check("rst_waddr", ms_rf_waddr, 64'h0);
    check("rst64_allowin", x_ms_allowin, 1'b1);
    $display("txn reset");
    resetn = 1'b1;
    step();
    check("post_rst_to_ws", ms_to_ws_valid, 1'b0);

    // ---- LD.B, response next cycle ----
    issue32(3'd1, 32'h1003, 1'b1, 1'b1, 5'd5, 32'h100);
    #1 check("t1_allowin", ms_allowin, 1'b1);
    step();
    es_to_ms_valid = 1'b0;
    #1;
    check("t1_wait_to_ws", ms_to_ws_valid, 1'b0);
    check("t1_wait_allowin", ms_allowin, 1'b0);
    data_ok = 1'b1;
    data_rdata = 32'h80FF_0000;
    #1;
    check("t1_valid", ms_to_ws_valid, 1'b1);
    check("t1_wdata", ms_rf_wdata, 64'hFFFF_FF80);
    check("t1_pc", ms_pc, 64'h100);
    check("t1_we", ms_rf_we, 1'b1);
    check("t1_waddr", ms_rf_waddr, 64'd5);
    check("t1_fwd", ms_fwd_valid, 1'b1);
    $display("txn LD.B addr=0x1003 wdata=0x%0h", ms_rf_wdata);
    step();
    data_ok = 1'b0;
    #1;
    check("t1_one_cycle", ms_to_ws_valid, 1'b0);
    check("t1_idle_allowin", ms_allowin, 1'b1);

    // ---- LD.HU, late response, WB stalled -> HOLD ----
    issue32(3'd4, 32'h2002, 1'b1, 1'b1, 5'd6, 32'h104);
    ws_allowin = 1'b0;
    step();
    es_to_ms_valid = 1'b0;
    for (int w = 0; w < 2; w++) begin
      #1;
      check("t2_wait_allowin", ms_allowin, 1'b0);
      check("t2_wait_to_ws", ms_to_ws_valid, 1'b0);
      step();
    end
    data_ok = 1'b1;
    data_rdata = 32'h80FF_1234;
    #1;
    check("t2_resp_to_ws", ms_to_ws_valid, 1'b1);
    check("t2_resp_allowin", ms_allowin, 1'b0);
    step();
    data_ok = 1'b0;
    data_rdata = 32'h5555_5555;
    #1;
    check("t2_hold_allowin", ms_allowin, 1'b0);
    check("t2_hold_to_ws", ms_to_ws_valid, 1'b1);
    check("t2_hold_wdata", ms_rf_wdata, 64'h0000_80FF);
    step();
    ws_allowin = 1'b1;
    #1;
    check("t2_release_allowin", ms_allowin, 1'b1);
    check("t2_release_wdata", ms_rf_wdata, 64'h0000_80FF);
    $display("txn LD.HU addr=0x2002 wdata=0x%0h", ms_rf_wdata);
    step();
    check("t2_done", ms_to_ws_valid, 1'b0);

    // ---- misaligned LD.W ----
    issue32(3'd0, 32'h3001, 1'b0, 1'b1, 5'd7, 32'h108);
    step();
    es_to_ms_valid = 1'b0;
    #1;
    check("t3_ale", ms_ale, 1'b1);
    check("t3_rf_we", ms_rf_we, 1'b0);
    check("t3_to_ws", ms_to_ws_valid, 1'b1);
    check("t3_fwd", ms_fwd_valid, 1'b0);
    $display("txn LD.W addr=0x3001 ale=%0b", ms_ale);
    step();
    check("t3_ale_clear", ms_ale, 1'b0);

    // ---- flush in WAIT, stray response later ----
    issue32(3'd0, 32'h4000, 1'b1, 1'b1, 5'd8, 32'h10C);
    step();
    es_to_ms_valid = 1'b0;
    flush = 1'b1;
    #1 check("t4_flush_to_ws", ms_to_ws_valid, 1'b0);
    step();
    flush = 1'b0;
    #1;
    check("t4_cancel_allowin", ms_allowin, 1'b0);
    check("t4_cancel_to_ws", ms_to_ws_valid, 1'b0);
    step();
    data_ok = 1'b1;
    data_rdata = 32'hDEAD_BEEF;
    #1;
    check("t4_drop_allowin", ms_allowin, 1'b0);
    check("t4_drop_to_ws", ms_to_ws_valid, 1'b0);
    check("t4_drop_we", ms_rf_we, 1'b0);
    step();
    data_ok = 1'b0;
    #1;
    check("t4_after_allowin", ms_allowin, 1'b1);
    check("t4_after_to_ws", ms_to_ws_valid, 1'b0);
    $display("txn flush+cancel addr=0x4000");

    // ---- back-to-back ALU ops ----
    for (int k = 0; k < 4; k++) begin
      issue32(3'd0, 32'h1111_0000 + k, 1'b0, 1'b0, 5'(10 + k), 32'h200 + 32'(4 * k));
      if (k > 0) begin
        #1;
        check("t5_allowin", ms_allowin, 1'b1);
        check("t5_to_ws", ms_to_ws_valid, 1'b1);
        check("t5_fwd", ms_fwd_valid, 1'b1);
        check("t5_wdata", ms_rf_wdata, 64'h1111_0000 + 64'(k - 1));
        $display("txn alu wdata=0x%0h", ms_rf_wdata);
      end
      step();
    end
    es_to_ms_valid = 1'b0;
    #1;
    check("t5_last_fwd", ms_fwd_valid, 1'b1);
    check("t5_last_wdata", ms_rf_wdata, 64'h1111_0003);
    step();
    check("t5_drain", ms_to_ws_valid, 1'b0);

    // ---- illegal ld_op at XLEN=32 acts as W (alignment included) ----
    issue32(3'd7, 32'h5002, 1'b0, 1'b1, 5'd9, 32'h300);
    step();
    es_to_ms_valid = 1'b0;
    #1 check("t6_illegal_ale", ms_ale, 1'b1);
    $display("txn op7 addr=0x5002 ale=%0b", ms_ale);
    step();
    issue32(3'd6, 32'h5004, 1'b1, 1'b1, 5'd9, 32'h304);
    step();
    es_to_ms_valid = 1'b0;
    data_ok = 1'b1;
    data_rdata = 32'h8765_4321;
    #1 check("t6_op6_as_w", ms_rf_wdata, 64'h8765_4321);
    $display("txn op6@32 wdata=0x%0h", ms_rf_wdata);
    step();
    data_ok = 1'b0;

    // ---- XLEN=64 ----
    load64("x_wu", 3'd5, 64'h1004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
    load64("x_w",  3'd0, 64'h1004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    load64("x_d",  3'd6, 64'h2000, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    load64("x_op7", 3'd7, 64'h3000, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001);
    load64("x_h",  3'd3, 64'h4006, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
    load64("x_bu", 3'd2, 64'h5007, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB);

    x_es_to_ms_valid  = 1'b1;
    x_es_ld_op        = 3'd6;
    x_es_alu_result   = 64'h6004;
    x_es_mem_req      = 1'b0;
    x_es_res_from_mem = 1'b1;
    step();
    x_es_to_ms_valid = 1'b0;
    #1;
    check("x_d_ale", x_ms_ale, 1'b1);
    check("x_d_ale_we", x_ms_rf_we, 1'b0);
    $display("txn xlen64 LD.D addr=0x6004 ale=%0b", x_ms_ale);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
